// File: rtl/bpu_pkg.sv
// Shared BPU types and constants for the BHT write-port controller.
// The optional BHT_WQ_MERGE_EN macro is consumed by bht_write_ctrl.
package bpu_pkg;

    localparam int BHT_IDX_W    = 10;
    localparam int BHT_ENTRY_W  = 64;
    localparam int BHT_WQ_DEPTH = 4;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        IDLE  = 1'b1
    } bht_wr_state_e;

    // Slot layout at the default table geometry.
    typedef struct packed {
        logic [BHT_IDX_W-1:0]   index;
        logic [BHT_ENTRY_W-1:0] entry;
    } bht_wq_slot_t;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/bht_wq_fifo.sv
// DEPTH-entry synchronous update queue with flush and a tail-overwrite port.
// The caller guarantees push is only raised when a slot is free (or a pop occurs).
module bht_wq_fifo
    import bpu_pkg::*;
#(
    parameter int IDX_W   = BHT_IDX_W,
    parameter int ENTRY_W = BHT_ENTRY_W,
    parameter int DEPTH   = BHT_WQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       flush,
    input  logic                       push,
    input  logic [IDX_W-1:0]           push_index,
    input  logic [ENTRY_W-1:0]         push_entry,
    input  logic                       pop,
    input  logic                       ovw,
    input  logic [ENTRY_W-1:0]         ovw_entry,
    output logic [IDX_W-1:0]           head_index,
    output logic [ENTRY_W-1:0]         head_entry,
    output logic [IDX_W-1:0]           tail_index,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [IDX_W-1:0]   idx_mem_r [DEPTH];
    logic [ENTRY_W-1:0] ent_mem_r [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_r;
    logic [PTR_W-1:0]   wr_ptr_r;
    logic [CNT_W-1:0]   count_r;
    logic [PTR_W-1:0]   tail_ptr_s;

    // Pointer arithmetic and read-side views of the queue.
    always_comb begin
        tail_ptr_s = wr_ptr_r - PTR_W'(1);
        head_index = idx_mem_r[rd_ptr_r];
        head_entry = ent_mem_r[rd_ptr_r];
        tail_index = idx_mem_r[tail_ptr_s];
        count      = count_r;
    end

    // Storage, pointers and occupancy; pointers wrap since DEPTH is a power of two.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            for (int i = 0; i < DEPTH; i++) begin
                idx_mem_r[i] <= {IDX_W{1'b0}};
                ent_mem_r[i] <= {ENTRY_W{1'b0}};
            end
        end else if (flush) begin
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push) begin
                idx_mem_r[wr_ptr_r] <= push_index;
                ent_mem_r[wr_ptr_r] <= push_entry;
                wr_ptr_r            <= wr_ptr_r + PTR_W'(1);
            end else if (ovw) begin
                ent_mem_r[tail_ptr_s] <= ovw_entry;
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push, pop})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/bht_write_ctrl.sv
// BHT write-port sequencer: clear sweep after reset/init_req, then in-order drain of EX updates.
// Define BHT_WQ_MERGE_EN to fold an update into the youngest queued entry with the same index.
module bht_write_ctrl
    import bpu_pkg::*;
#(
    parameter int IDX_W   = BHT_IDX_W,
    parameter int ENTRY_W = BHT_ENTRY_W,
    parameter int DEPTH   = BHT_WQ_DEPTH
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       init_req,
    input  logic                       upd_valid,
    input  logic [IDX_W-1:0]           upd_index,
    input  logic [ENTRY_W-1:0]         upd_entry,
    output logic                       wr_en,
    output logic [IDX_W-1:0]           wr_addr,
    output logic [ENTRY_W-1:0]         wr_data,
    output logic                       init_busy,
    output logic [$clog2(DEPTH+1)-1:0] q_count,
    output logic [15:0]                drop_cnt
);

    localparam int               CNT_W    = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [IDX_W-1:0] PTR_LAST = {IDX_W{1'b1}};
`ifdef BHT_WQ_MERGE_EN
    localparam logic MERGE_EN = 1'b1;
`else
    localparam logic MERGE_EN = 1'b0;
`endif

    bht_wr_state_e      state_r;
    logic [IDX_W-1:0]   sweep_ptr_r;
    logic               wr_en_r;
    logic [IDX_W-1:0]   wr_addr_r;
    logic [ENTRY_W-1:0] wr_data_r;
    logic               init_busy_r;
    logic [15:0]        drop_cnt_r;

    logic               idle_s;
    logic               fifo_empty_s;
    logic               pop_s;
    logic               bypass_s;
    logic               want_q_s;
    logic               merge_s;
    logic               push_s;
    logic               drop_s;
    logic [IDX_W-1:0]   head_index_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic [IDX_W-1:0]   tail_index_s;
    logic [CNT_W-1:0]   q_count_s;

    bht_wq_fifo #(
        .IDX_W   (IDX_W),
        .ENTRY_W (ENTRY_W),
        .DEPTH   (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .resetn     (resetn),
        .flush      (init_req),
        .push       (push_s),
        .push_index (upd_index),
        .push_entry (upd_entry),
        .pop        (pop_s),
        .ovw        (merge_s),
        .ovw_entry  (upd_entry),
        .head_index (head_index_s),
        .head_entry (head_entry_s),
        .tail_index (tail_index_s),
        .count      (q_count_s)
    );

    // Per-cycle queue decisions; init_req discards everything in flight.
    always_comb begin
        idle_s       = (state_r == IDLE);
        fifo_empty_s = (q_count_s == {CNT_W{1'b0}});
        pop_s        = idle_s && !fifo_empty_s && !init_req;
        bypass_s     = idle_s && fifo_empty_s && upd_valid && !init_req;
        want_q_s     = upd_valid && !bypass_s && !init_req;
        // A youngest entry being popped this cycle cannot absorb a merge.
        merge_s      = MERGE_EN && want_q_s && !fifo_empty_s
                       && (tail_index_s == upd_index)
                       && !(pop_s && (q_count_s == CNT_W'(1)));
        push_s       = want_q_s && !merge_s && ((q_count_s != DEPTH_C) || pop_s);
        drop_s       = want_q_s && !merge_s && !push_s;
    end

    // Write-port FSM: sweep has priority, then FIFO head, then bypass.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r     <= SWEEP;
            sweep_ptr_r <= {IDX_W{1'b0}};
            wr_en_r     <= 1'b0;
            wr_addr_r   <= {IDX_W{1'b0}};
            wr_data_r   <= {ENTRY_W{1'b0}};
            init_busy_r <= 1'b1;
        end else if (init_req) begin
            state_r     <= SWEEP;
            sweep_ptr_r <= {IDX_W{1'b0}};
            wr_en_r     <= 1'b0;
            init_busy_r <= 1'b1;
        end else begin
            case (state_r)
                SWEEP: begin
                    wr_en_r     <= 1'b1;
                    wr_addr_r   <= sweep_ptr_r;
                    wr_data_r   <= {ENTRY_W{1'b0}};
                    sweep_ptr_r <= sweep_ptr_r + IDX_W'(1);
                    init_busy_r <= 1'b1;
                    if (sweep_ptr_r == PTR_LAST) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= SWEEP;
                    end
                end
                IDLE: begin
                    init_busy_r <= 1'b0;
                    if (pop_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= head_index_s;
                        wr_data_r <= head_entry_s;
                    end else if (bypass_s) begin
                        wr_en_r   <= 1'b1;
                        wr_addr_r <= upd_index;
                        wr_data_r <= upd_entry;
                    end else begin
                        wr_en_r <= 1'b0;
                    end
                end
                default: begin
                    state_r     <= SWEEP;
                    sweep_ptr_r <= {IDX_W{1'b0}};
                    wr_en_r     <= 1'b0;
                    init_busy_r <= 1'b1;
                end
            endcase
        end
    end

    // Saturating count of updates lost to a full queue.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            drop_cnt_r <= 16'd0;
        end else if (drop_s) begin
            drop_cnt_r <= sat_inc16(drop_cnt_r);
        end else begin
            drop_cnt_r <= drop_cnt_r;
        end
    end

    assign wr_en     = wr_en_r;
    assign wr_addr   = wr_addr_r;
    assign wr_data   = wr_data_r;
    assign init_busy = init_busy_r;
    assign q_count   = q_count_s;
    assign drop_cnt  = drop_cnt_r;

endmodule
